i2s_adc_capture: RTL
====================

I2S_ADC_CAPTURE -- requirements
Module: i2s_adc_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 16: captured sample width, MSB first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on BCLK/LRCK/DAT.
REQ-003 SHALL have parameter TR_WIDTH, default 4: SAMPLE_TR high time in AUDIO_MCLK cycles.
REQ-004 AUDIO_MCLK  in  1  sole clock; all logic on its rising edge.
REQ-005 RESET  in  1  reset, asynchronous, active-high.
REQ-006 ADC_BCLK  in  1  codec bit clock, asynchronous to AUDIO_MCLK.
REQ-007 ADC_LRCK  in  1  codec word select: 0 = left, 1 = right; asynchronous.
REQ-008 ADC_DAT  in  1  codec serial data, I2S format; asynchronous.
REQ-009 CH_SEL  in  1  channel published on WAVE: 0 = left, 1 = right; sampled at each LRCK edge.
REQ-010 WAVE  out  DATA_W  last published sample, two's complement.
REQ-011 SAMPLE_TR  out  1  registered sample strobe; WAVE stable while high; usable as a write clock.
REQ-012 FRAME_ERR  out  1  one-cycle pulse: word cut short by an LRCK edge.
REQ-013 OVERRUN  out  1  one-cycle pulse: word completed while SAMPLE_TR still high; word dropped.

Function
REQ-014 SHALL synchronise BCLK, LRCK and DAT through SYNC_STAGES flops; BCLK rising edge = synced high & previous synced low.
REQ-015 SHALL sample DAT only on detected BCLK rising edges; AUDIO_MCLK SHALL be >= 4x BCLK; slower ratios are unsupported.
REQ-016 SHALL implement states IDLE, SKIP, SHIFT, HOLD.
REQ-017 IDLE: after reset; on first detected LRCK edge -> SKIP.
REQ-018 SKIP: first BCLK rising edge after an LRCK edge is the I2S delay bit, discarded -> SHIFT, bit count 0.
REQ-019 SHIFT: each BCLK rising edge shifts DAT into the LSB of the shift register; on the DATA_W-th bit -> HOLD.
REQ-020 HOLD: further bits of the slot are ignored; on LRCK edge -> SKIP.
REQ-021 An LRCK edge in SHIFT with bit count < DATA_W SHALL pulse FRAME_ERR, discard the partial word, go to SKIP.
REQ-022 An LRCK edge and BCLK edge detected in the same cycle SHALL be handled as LRCK first; that BCLK edge counts as the SKIP bit.
REQ-023 The channel of a word SHALL be the LRCK level latched at its start edge; only words whose channel equals the latched CH_SEL are published.
REQ-024 Publish: WAVE loads the word in the cycle after the DATA_W-th bit's detected edge; SAMPLE_TR rises the following cycle and stays high exactly TR_WIDTH cycles.
REQ-025 WAVE SHALL NOT change while SAMPLE_TR is high or during the cycle before it rises.
REQ-026 If a selected word completes while SAMPLE_TR is high, SHALL pulse OVERRUN and leave WAVE unchanged.
REQ-027 A CH_SEL change SHALL take effect at the next LRCK edge; it never aborts a word in progress.

Reset
REQ-028 RESET high SHALL asynchronously force: state IDLE, WAVE 0, SAMPLE_TR 0, FRAME_ERR 0, OVERRUN 0, bit count 0, shift register 0, synchronisers 0.
REQ-029 Deassertion mid-frame SHALL yield no output until a complete word follows a fresh LRCK edge.

Structure
REQ-030 Shared package audio_pkg SHALL hold the state enumeration, DATA_W default and I2S left/right encoding constants.
REQ-031 One sub-module, sync_edge_det (SYNC_STAGES synchroniser + rise/fall detect), SHALL be instantiated for BCLK and LRCK; DAT uses the synchroniser only.

Verification
REQ-032 MCLK 12.288 MHz, BCLK 3.072 MHz, left words 0x8001, 0x7FFE, CH_SEL 0 -> WAVE 0x8001 then 0x7FFE, one 4-cycle SAMPLE_TR per left word, no flags.
REQ-033 Same stream, CH_SEL 1, right word 0x1234 -> only 0x1234 published; left words never appear.
REQ-034 LRCK toggles after 10 data bits -> FRAME_ERR one pulse; WAVE keeps prior value; next full word publishes normally.
REQ-035 24 bits per slot, DATA_W 16, data 0xABCDEF -> WAVE 0xABCD; trailing 8 bits ignored.
REQ-036 TR_WIDTH 64 with back-to-back selected words -> second word gives OVERRUN pulse, WAVE unchanged.
REQ-037 RESET asserted mid-SHIFT -> all outputs 0 immediately; after release, first publish only after a new LRCK edge plus a full word.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the I2S capture path: FSM states, default word width
// and the LRCK level encoding of the left/right channels.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_SHIFT,
        ST_HOLD
    } cap_state_e;

    localparam int DATA_W_DEFAULT = 16;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input plus rise/fall detection
// on the synchronised level.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   prime_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d_i};
            prev_q  <= sync_q[STAGES-1];
            prime_q <= {prime_q[STAGES-1:0], 1'b1};
        end
    end

    // Edges are masked until the chain holds real samples, so a line that is
    // already high when reset releases does not look like a fresh transition.
    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = prime_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = prime_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/i2s_adc_capture.sv
// I2S receiver running entirely in the AUDIO_MCLK domain: captures one channel's
// MSB-first words and publishes them on WAVE with a fixed-width SAMPLE_TR strobe.
module i2s_adc_capture
    import audio_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int TR_WIDTH    = 4
) (
    input  logic              AUDIO_MCLK,
    input  logic              RESET,
    input  logic              ADC_BCLK,
    input  logic              ADC_LRCK,
    input  logic              ADC_DAT,
    input  logic              CH_SEL,
    output logic [DATA_W-1:0] WAVE,
    output logic              SAMPLE_TR,
    output logic              FRAME_ERR,
    output logic              OVERRUN
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int TRC_W = $clog2(TR_WIDTH + 1);

    logic bclk_lvl, bclk_rise, bclk_fall;
    logic lrck_lvl, lrck_rise, lrck_fall;
    logic lrck_edge, dat_s;
    logic unused_bclk;

    logic [SYNC_STAGES-1:0] dat_sync_q;

    cap_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              chan_q, chan_d;
    logic              sel_q, sel_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic [DATA_W-1:0] wave_q, wave_d;
    logic              start_q, start_d;
    logic              tr_q, tr_d;
    logic [TRC_W-1:0]  trc_q, trc_d;
    logic              ovr_q, ovr_d;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk (
        .clk_i  (AUDIO_MCLK),
        .rst_i  (RESET),
        .d_i    (ADC_BCLK),
        .lvl_o  (bclk_lvl),
        .rise_o (bclk_rise),
        .fall_o (bclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_lrck (
        .clk_i  (AUDIO_MCLK),
        .rst_i  (RESET),
        .d_i    (ADC_LRCK),
        .lvl_o  (lrck_lvl),
        .rise_o (lrck_rise),
        .fall_o (lrck_fall)
    );

    assign unused_bclk = bclk_lvl ^ bclk_fall;
    assign lrck_edge   = lrck_rise | lrck_fall;
    // Same depth as the BCLK chain, so dat_s is the level seen at the BCLK rise.
    assign dat_s       = dat_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        chan_d  = chan_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        wave_d  = wave_q;
        start_d = 1'b0;
        ovr_d   = 1'b0;
        tr_d    = tr_q;
        trc_d   = trc_q;

        // An LRCK edge wins over a simultaneous BCLK rise; that rise is the delay bit.
        if (lrck_edge) begin
            chan_d  = lrck_lvl ? I2S_RIGHT : I2S_LEFT;
            sel_d   = CH_SEL ? I2S_RIGHT : I2S_LEFT;
            cnt_d   = '0;
            shreg_d = '0;
            ferr_d  = (state_q == ST_SHIFT);
            state_d = bclk_rise ? ST_SHIFT : ST_SKIP;
        end else begin
            unique case (state_q)
                ST_SKIP: begin
                    if (bclk_rise) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                    end
                end
                ST_SHIFT: begin
                    if (bclk_rise) begin
                        shreg_d = {shreg_q[DATA_W-2:0], dat_s};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = ST_HOLD;
                            done_d  = (chan_q == sel_q);
                        end
                    end
                end
                default: ;
            endcase
        end

        // The completed word stays in shreg_q (HOLD) for the cycle after done.
        if (done_q) begin
            if (start_q || tr_q) begin
                ovr_d = 1'b1;
            end else begin
                wave_d  = shreg_q;
                start_d = 1'b1;
            end
        end

        if (start_q) begin
            tr_d  = 1'b1;
            trc_d = TRC_W'(TR_WIDTH - 1);
        end else if (tr_q) begin
            if (trc_q == '0) begin
                tr_d = 1'b0;
            end else begin
                trc_d = trc_q - TRC_W'(1);
            end
        end
    end

    always_ff @(posedge AUDIO_MCLK or posedge RESET) begin
        if (RESET) begin
            dat_sync_q <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            chan_q     <= I2S_LEFT;
            sel_q      <= I2S_LEFT;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            wave_q     <= '0;
            start_q    <= 1'b0;
            tr_q       <= 1'b0;
            trc_q      <= '0;
            ovr_q      <= 1'b0;
        end else begin
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ADC_DAT};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            chan_q     <= chan_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            wave_q     <= wave_d;
            start_q    <= start_d;
            tr_q       <= tr_d;
            trc_q      <= trc_d;
            ovr_q      <= ovr_d;
        end
    end

    assign WAVE      = wave_q;
    assign SAMPLE_TR = tr_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;

endmodule
